// File: rtl/prbs_pkg.sv
// Shared types and default sizing for the PRBS BER monitor slice.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    DONE
  } ber_state_t;

  localparam int unsigned BER_CNT_W  = 16;
  localparam int unsigned BER_LOCK_N = 8;
  localparam int unsigned BER_LOSS_N = 4;

endpackage

// File: rtl/prbs_run_counter.sv
// Saturating consecutive-run counter. hit flags the cycle whose inc brings
// the run to N, so the owner can react on that same sample.
module prbs_run_counter
  import prbs_pkg::*;
#(
  parameter int unsigned N = BER_LOCK_N
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int unsigned W    = $clog2(N + 1);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] FULL = W'(N);

  logic [W-1:0] run;

  assign hit = inc && !clr && (run >= LAST);

  // Run length: cleared on clr, otherwise counts inc up to N and holds there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run <= '0;
    end else if (clr) begin
      run <= '0;
    end else if (inc && (run != FULL)) begin
      run <= run + W'(1);
    end
  end

endmodule

// File: rtl/prbs_ber_monitor.sv
// Bit-error-rate monitor: locks on a clean pass run, counts bits and errors
// over a programmable window, tracks lock loss and reports a verdict.
module prbs_ber_monitor
  import prbs_pkg::*;
#(
  parameter int unsigned CNT_W      = BER_CNT_W,
  parameter int unsigned LOCK_N     = BER_LOCK_N,
  parameter int unsigned LOSS_N     = BER_LOSS_N,
  parameter int unsigned ERR_THRESH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pass,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window_len,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat,
  output logic             lock_lost,
  output logic             ber_ok
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

  ber_state_t       state, state_n;
  logic [CNT_W-1:0] window, win_n, bit_n, err_n;
  logic             sat_n, lost_n, done_n, ok_n;
  logic             pass_inc, pass_clr, pass_hit;
  logic             fail_inc, fail_clr, fail_hit;

  prbs_run_counter #(.N(LOCK_N)) u_pass_run (
    .clk   (clk),
    .reset (reset),
    .inc   (pass_inc),
    .clr   (pass_clr),
    .hit   (pass_hit)
  );

  prbs_run_counter #(.N(LOSS_N)) u_fail_run (
    .clk   (clk),
    .reset (reset),
    .inc   (fail_inc),
    .clr   (fail_clr),
    .hit   (fail_hit)
  );

  // Next-state and next-output evaluation: abort > start > sample processing.
  // Window end is tested before lock loss so a coincident LOSS_N still lands in DONE.
  always_comb begin
    state_n  = state;
    win_n    = window;
    bit_n    = bit_count;
    err_n    = err_count;
    sat_n    = err_sat;
    lost_n   = lock_lost;
    ok_n     = ber_ok;
    done_n   = 1'b0;
    pass_inc = 1'b0;
    pass_clr = 1'b0;
    fail_inc = 1'b0;
    fail_clr = 1'b0;
    if (abort) begin
      state_n  = IDLE;
      bit_n    = '0;
      err_n    = '0;
      sat_n    = 1'b0;
      lost_n   = 1'b0;
      ok_n     = 1'b0;
      pass_clr = 1'b1;
      fail_clr = 1'b1;
    end else if (start && (state == IDLE || state == DONE)) begin
      state_n  = ACQUIRE;
      win_n    = window_len;
      bit_n    = '0;
      err_n    = '0;
      sat_n    = 1'b0;
      lost_n   = 1'b0;
      ok_n     = 1'b0;
      pass_clr = 1'b1;
      fail_clr = 1'b1;
    end else begin
      case (state)
        ACQUIRE: begin
          fail_clr = 1'b1;
          if (en) begin
            if (pass) begin
              pass_inc = 1'b1;
              if (pass_hit) state_n = MEASURE;
            end else begin
              pass_clr = 1'b1;
            end
          end
        end
        MEASURE: begin
          pass_clr = 1'b1;
          if (window == '0) begin
            fail_clr = 1'b1;
            state_n  = DONE;
            done_n   = 1'b1;
            ok_n     = (err_count <= THRESH) && !lock_lost;
          end else if (en) begin
            bit_n = bit_count + CNT_W'(1);
            if (!pass) begin
              fail_inc = 1'b1;
              if (err_count != '1) err_n = err_count + CNT_W'(1);
              if (err_n == '1) sat_n = 1'b1;
            end else begin
              fail_clr = 1'b1;
            end
            if (bit_n == window) begin
              state_n = DONE;
              done_n  = 1'b1;
              if (fail_hit) lost_n = 1'b1;
              ok_n    = (err_n <= THRESH) && !lost_n;
            end else if (fail_hit) begin
              state_n = ACQUIRE;
              lost_n  = 1'b1;
            end
          end
        end
        default: begin
          pass_clr = 1'b1;
          fail_clr = 1'b1;
        end
      endcase
    end
  end

  // State and all outputs registered; busy/locked decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      window    <= '0;
      bit_count <= '0;
      err_count <= '0;
      err_sat   <= 1'b0;
      lock_lost <= 1'b0;
      ber_ok    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      window    <= win_n;
      bit_count <= bit_n;
      err_count <= err_n;
      err_sat   <= sat_n;
      lock_lost <= lost_n;
      ber_ok    <= ok_n;
      done      <= done_n;
      busy      <= (state_n == ACQUIRE) || (state_n == MEASURE);
      locked    <= (state_n == MEASURE);
    end
  end

endmodule
